// File: rtl/kab_irq_pkg.sv
// kab_irq_pkg: register map and FSM encoding shared
// by the Kab external interrupt controller files.
package kab_irq_pkg;

  localparam logic [3:0] IRQ_ENABLE_ADDR = 4'd0;
  localparam logic [3:0] IRQ_MODE_ADDR   = 4'd1;
  localparam logic [3:0] IRQ_PEND_ADDR   = 4'd2;
  localparam logic [3:0] IRQ_STATUS_ADDR = 4'd3;
  localparam logic [3:0] IRQ_GLOBAL_ADDR = 4'd4;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_GAP
  } irq_state_t;

endpackage

// File: rtl/kab_irq_prio_enc.sv
// kab_irq_prio_enc: combinational priority encoder,
// highest set index wins.
module kab_irq_prio_enc
  import kab_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] Req,
  output logic               Valid,
  output logic [ID_W-1:0]    Id
);

  // scan upward so the last hit is the highest index
  always_comb begin
    Valid = |Req;
    Id    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (Req[i]) Id = ID_W'(i);
    end
  end

endmodule

// File: rtl/kab_irq_ctrl.sv
// kab_irq_ctrl: external interrupt controller with edge/level lines.
// Build option: KAB_IRQ_SYNC_EN adds a 2-flop input synchroniser.
module kab_irq_ctrl
  import kab_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_IRQ-1:0] IrqIn,
  input  logic               Sys_BlockSelect,
  input  logic [3:0]         Sys_Address,
  input  logic               Sys_WrEn,
  input  logic               Sys_RdEn,
  input  logic [31:0]        Sys_WrData,
  output logic [31:0]        Sys_RdData,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  input  logic               EIC_IntAck
);

  logic [NUM_IRQ-1:0] r_enable;
  logic [NUM_IRQ-1:0] r_mode;
  logic [NUM_IRQ-1:0] r_edge;
  logic [NUM_IRQ-1:0] r_irq_d;
  logic               r_global;
  irq_state_t         r_state;
  irq_state_t         w_state_nxt;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    w_id_nxt;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;

  logic [NUM_IRQ-1:0] w_irq;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_wdata;
  logic               w_valid;
  logic [ID_W-1:0]    w_win;
  logic               w_wr;
  logic               w_rd;
  logic               w_ack;
  logic               w_unused;

`ifdef KAB_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  // two-flop synchroniser for asynchronous sources
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= IrqIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq = r_sync2;
`else
  assign w_irq = IrqIn;
`endif

  assign w_wr     = Sys_BlockSelect & Sys_WrEn;
  assign w_rd     = Sys_BlockSelect & Sys_RdEn;
  assign w_wdata  = Sys_WrData[NUM_IRQ-1:0];
  assign w_unused = &{1'b0, Sys_WrData};

  // edge lines show the latched bit, level lines the live input
  assign w_pend = (r_edge & r_mode) | (w_irq & ~r_mode);
  assign w_elig = w_pend & r_enable & {NUM_IRQ{r_global}};
  assign w_rise = w_irq & ~r_irq_d & r_mode;
  assign w_ack  = (r_state == IRQ_REQ) & EIC_IntAck;

  kab_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio (
    .Req   (w_elig),
    .Valid (w_valid),
    .Id    (w_win)
  );

  // edge-pending clears from W1C and from acking an edge line
  always_comb begin
    w_clr = '0;
    if (w_wr && Sys_Address == IRQ_PEND_ADDR) begin
      w_clr = w_wdata & r_mode;
    end
    if (w_ack && r_mode[r_id]) begin
      w_clr[r_id] = 1'b1;
    end
  end

  // edge latch: a new rising edge beats a same-cycle clear
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_edge  <= '0;
      r_irq_d <= '0;
    end else begin
      r_edge  <= (r_edge & ~w_clr) | w_rise;
      r_irq_d <= w_irq;
    end
  end

  // configuration registers
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_enable <= '0;
      r_mode   <= '0;
      r_global <= 1'b0;
    end else if (w_wr) begin
      case (Sys_Address)
        IRQ_ENABLE_ADDR: r_enable <= w_wdata;
        IRQ_MODE_ADDR:   r_mode   <= w_wdata;
        IRQ_GLOBAL_ADDR: r_global <= Sys_WrData[0];
        default: ;
      endcase
    end
  end

  // read mux, zero-extended; unmapped reads give 0
  always_comb begin
    w_rdata = '0;
    case (Sys_Address)
      IRQ_ENABLE_ADDR: w_rdata[NUM_IRQ-1:0] = r_enable;
      IRQ_MODE_ADDR:   w_rdata[NUM_IRQ-1:0] = r_mode;
      IRQ_PEND_ADDR:   w_rdata[NUM_IRQ-1:0] = w_pend;
      IRQ_STATUS_ADDR: begin
        w_rdata[31]        = EIC_IntReq;
        w_rdata[ID_W-1:0]  = r_id;
      end
      IRQ_GLOBAL_ADDR: w_rdata[0] = r_global;
      default: ;
    endcase
  end

  // read data holds until the next qualified read
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_rdata <= '0;
    end else if (w_rd) begin
      r_rdata <= w_rdata;
    end
  end

  // handshake FSM state and latched id
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_state <= IRQ_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // next state: request is held until acked, then one idle gap
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    unique case (r_state)
      IRQ_IDLE: begin
        if (w_valid) begin
          w_id_nxt    = w_win;
          w_state_nxt = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (EIC_IntAck) w_state_nxt = IRQ_GAP;
      end
      IRQ_GAP: w_state_nxt = IRQ_IDLE;
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  assign EIC_IntReq = (r_state == IRQ_REQ);
  assign EIC_IntId  = r_id;
  assign Sys_RdData = r_rdata;

endmodule

// File: tb/tb_kab_irq_ctrl.sv
// tb_kab_irq_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model of the controller.
module tb_kab_irq_ctrl;

  localparam int N = 8;
`ifdef KAB_IRQ_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT  = 2 + SD;
  localparam int LATL = 1 + SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic          sel = 1'b0;
  logic [3:0]    addr = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          req;
  logic [2:0]    id;
  logic          ack = 1'b0;

  int n_run  = 0;
  int n_fail = 0;

  kab_irq_ctrl #(.NUM_IRQ(N)) dut (
    .Sys_Clock       (clk),
    .Sys_Reset       (rst_n),
    .IrqIn           (irq),
    .Sys_BlockSelect (sel),
    .Sys_Address     (addr),
    .Sys_WrEn        (wr),
    .Sys_RdEn        (rd),
    .Sys_WrData      (wdata),
    .Sys_RdData      (rdata),
    .EIC_IntReq      (req),
    .EIC_IntId       (id),
    .EIC_IntAck      (ack)
  );

  always #5 clk = ~clk;

  // behavioural model
  logic [N-1:0] m_en, m_mode, m_edge, m_prev, m_s1, m_s2;
  logic         m_glob;
  int           m_phase;
  int           m_id;
  logic [31:0]  m_rd;

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_edge = '0; m_prev = '0;
    m_s1 = '0; m_s2 = '0; m_glob = 1'b0;
    m_phase = 0; m_id = 0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] ie, pv, el, clr, rise;
    int win;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ie = (SD > 0) ? m_s2 : irq;
    pv = (m_edge & m_mode) | (ie & ~m_mode);
    el = m_glob ? (pv & m_en) : '0;
    win = -1;
    for (int i = 0; i < N; i++) if (el[i]) win = i;
    rise = ie & ~m_prev & m_mode;
    clr = '0;
    if (sel && wr && addr == 4'd2) clr = wdata[N-1:0] & m_mode;
    if (m_phase == 1 && ack && m_mode[m_id]) clr[m_id] = 1'b1;
    if (sel && rd) begin
      case (addr)
        4'd0: m_rd = {24'd0, m_en};
        4'd1: m_rd = {24'd0, m_mode};
        4'd2: m_rd = {24'd0, pv};
        4'd3: m_rd = ((m_phase == 1) ? 32'h8000_0000 : 32'h0) | 32'(m_id);
        4'd4: m_rd = {31'd0, m_glob};
        default: m_rd = '0;
      endcase
    end
    if (sel && wr) begin
      case (addr)
        4'd0: m_en = wdata[N-1:0];
        4'd1: m_mode = wdata[N-1:0];
        4'd4: m_glob = wdata[0];
        default: ;
      endcase
    end
    m_edge = (m_edge & ~clr) | rise;
    case (m_phase)
      0: if (win >= 0) begin m_id = win; m_phase = 1; end
      1: if (ack) m_phase = 2;
      default: m_phase = 0;
    endcase
    m_prev = ie;
    m_s2 = m_s1;
    m_s1 = irq;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_req", 32'(req), 32'(m_phase == 1));
    chk("m_id", 32'(id), 32'(m_id));
    chk("m_rd", rdata, m_rd);
  endtask

  task automatic wreg(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    cyc();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic rreg(input logic [3:0] a);
    sel = 1'b1; rd = 1'b1; addr = a;
    cyc();
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq = v;
    cyc();
    irq = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    cyc();
    cyc();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_id", 32'(id), 32'd0);
    chk("rst_rd", rdata, 32'd0);
    rst_n = 1'b1;

    // single edge on IRQ3
    wreg(4'd0, 32'hFF);
    wreg(4'd1, 32'hFF);
    wreg(4'd4, 32'h1);
    pulse(8'h08);
    for (int i = 1; i < LAT - 1; i++) cyc();
    chk("s1_early", 32'(req), 32'd0);
    cyc();
    chk("s1_req", 32'(req), 32'd1);
    chk("s1_id", 32'(id), 32'd3);
    do_ack();
    chk("s1_gap", 32'(req), 32'd0);
    cyc();
    chk("s1_low1", 32'(req), 32'd0);
    cyc();
    chk("s1_low2", 32'(req), 32'd0);
    rreg(4'd2);
    chk("s1_pend", rdata, 32'h00);

    // simultaneous edges on IRQ2 and IRQ6
    pulse(8'h44);
    for (int i = 1; i < LAT; i++) cyc();
    chk("s2_id6", 32'(id), 32'd6);
    do_ack();
    chk("s2_gap", 32'(req), 32'd0);
    cyc();
    chk("s2_idle", 32'(req), 32'd0);
    cyc();
    chk("s2_req2", 32'(req), 32'd1);
    chk("s2_id2", 32'(id), 32'd2);
    do_ack();
    rreg(4'd2);
    chk("s2_pend", rdata, 32'h00);
    cyc();

    // level line IRQ5
    wreg(4'd1, 32'h00);
    irq = 8'h20;
    for (int i = 0; i < LATL; i++) cyc();
    chk("s3_id5", 32'(id), 32'd5);
    chk("s3_req", 32'(req), 32'd1);
    do_ack();
    chk("s3_gap", 32'(req), 32'd0);
    cyc();
    cyc();
    chk("s3_rereq", 32'(req), 32'd1);
    chk("s3_reid", 32'(id), 32'd5);
    irq = '0;
    for (int i = 0; i <= SD; i++) cyc();
    do_ack();
    for (int i = 0; i < 4; i++) cyc();
    chk("s3_quiet", 32'(req), 32'd0);

    // masked edge on IRQ1
    wreg(4'd1, 32'hFF);
    wreg(4'd0, 32'h00);
    pulse(8'h02);
    for (int i = 1; i < LAT; i++) cyc();
    rreg(4'd2);
    chk("s4_pend", rdata, 32'h02);
    chk("s4_noreq", 32'(req), 32'd0);
    wreg(4'd0, 32'h02);
    cyc();
    chk("s4_req", 32'(req), 32'd1);
    chk("s4_id1", 32'(id), 32'd1);
    do_ack();
    cyc();
    wreg(4'd0, 32'h00);
    pulse(8'h02);
    for (int i = 1; i < LAT; i++) cyc();
    wreg(4'd2, 32'h02);
    wreg(4'd0, 32'h02);
    cyc();
    cyc();
    chk("s4_w1c", 32'(req), 32'd0);

    // ack racing a new IRQ4 edge
    wreg(4'd0, 32'hFF);
    pulse(8'h10);
    for (int i = 1; i < LAT; i++) cyc();
    chk("s5_id4", 32'(id), 32'd4);
    if (SD > 0) begin
      pulse(8'h10);
      cyc();
      do_ack();
    end else begin
      irq = 8'h10;
      ack = 1'b1;
      cyc();
      irq = '0;
      ack = 1'b0;
    end
    rreg(4'd2);
    chk("s5_pend4", rdata, 32'h10);
    cyc();
    cyc();
    chk("s5_rereq", 32'(req), 32'd1);
    chk("s5_reid", 32'(id), 32'd4);
    do_ack();
    cyc();
    cyc();

    // reset in the middle of a request
    pulse(8'h80);
    for (int i = 1; i < LAT; i++) cyc();
    chk("s6_req", 32'(req), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6_async", 32'(req), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int a = 0; a < 5; a++) begin
      rreg(4'(a));
      chk("s6_reg0", rdata, 32'd0);
    end

    // random traffic against the model
    wreg(4'd0, 32'hFF);
    wreg(4'd4, 32'h1);
    for (int k = 0; k < 600; k++) begin
      int r;
      irq = N'($urandom) & N'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      sel = 1'b0; wr = 1'b0; rd = 1'b0;
      r = $urandom_range(0, 9);
      addr = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if (r == 0) begin
        sel = 1'b1; wr = 1'b1;
        addr = 4'($urandom_range(0, 5));
        if (addr == 4'd4) wdata[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 5) begin
        sel = 1'b1; rd = 1'b1;
        if (r < 4) addr = 4'($urandom_range(0, 4));
      end else if (r == 5) begin
        wr = 1'b1;
      end
      cyc();
    end
    irq = '0; ack = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
